moving_average_stream: RTL and testbench

Parametrised streaming moving-average filter; successor to the fixed 8-bit, 16-tap, always-enabled mealy averager.
- Adds configurable data width and window depth.
- Adds a full-precision accumulator with no wrap-around, and a selectable SUM or AVERAGE output mode.
- Adds valid/ready handshaking on both sides, a registered output, a warm-up gate and a synchronous clear.
- Sits between a sample source (ADC/decimator) and downstream DSP in the system1000 domain.

---
 rtl/moving_average_stream_pkg.sv | 15 +
 rtl/sample_delay_line.sv | 31 +++
 rtl/moving_average_stream.sv | 105 ++++++++++
 tb/tb_moving_average_stream.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/moving_average_stream_pkg.sv
// Shared types and width helpers for the moving-average streaming filter.
package moving_average_pkg;

  // Output selection: raw window sum, or sum scaled down by the window depth.
  typedef enum logic {
    MA_SUM     = 1'b0,
    MA_AVERAGE = 1'b1
  } ma_mode_e;

  // Accumulator width that holds DEPTH full-scale samples without wrapping.
  function automatic int acc_width(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

endpackage

// File: rtl/sample_delay_line.sv
// Enabled shift register of DEPTH samples; tap 0 is the newest, the
// oldest tap is exposed so a running-sum filter can subtract it.
module sample_delay_line #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] oldest_o
);

  logic [DATA_W-1:0] taps_q [DEPTH];

  // Shift on enable; clear and reset both empty the window to zeros.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) taps_q[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) taps_q[i] <= '0;
    end else if (en_i) begin
      taps_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) taps_q[i] <= taps_q[i-1];
    end
  end

  assign oldest_o = taps_q[DEPTH-1];

endmodule

// File: rtl/moving_average_stream.sv
// Streaming moving-average filter: running window sum with a registered
// SUM/AVERAGE output, a warm-up gate and a synchronous clear.
//
// Handshake: a sample transfers on a clock edge where in_valid && in_ready;
// a result transfers where out_valid && out_ready. in_ready is
// !out_valid || out_ready, so a stalled output freezes the whole block and
// the only combinational input-to-output path is out_ready -> in_ready.
module moving_average_stream
  import moving_average_pkg::*;
#(
  parameter int       DATA_W     = 8,
  parameter int       LOG2_DEPTH = 4,
  parameter ma_mode_e MODE       = MA_AVERAGE,
  parameter int       WARMUP     = 1
) (
  input  logic                                 system1000,
  input  logic                                 system1000_rst,
  input  logic                                 clear,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic        [DATA_W-1:0]             in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [DATA_W+LOG2_DEPTH-1:0]  out_data,
  output logic signed [DATA_W+LOG2_DEPTH-1:0]  out_sum,
  output logic                                 window_full
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int ACC_W = acc_width(DATA_W, LOG2_DEPTH);
  localparam int EXT_W = ACC_W - DATA_W;
  localparam int CNT_W = LOG2_DEPTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic signed [ACC_W-1:0] out_data_q, out_data_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;

  logic                    accept;
  logic        [DATA_W-1:0] oldest;
  logic signed [ACC_W-1:0] sum_next;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  sample_delay_line #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_delay (
    .clk_i    (system1000),
    .rst_i    (system1000_rst),
    .clear_i  (clear),
    .en_i     (accept),
    .data_i   (in_data),
    .oldest_o (oldest)
  );

  // Sign-extend both ends of the window so the sum is exact at full scale.
  assign sum_next = sum_q
                  + $signed({{EXT_W{in_data[DATA_W-1]}}, in_data})
                  - $signed({{EXT_W{oldest[DATA_W-1]}}, oldest});

  // Next-state: clear beats accept; an idle transfer drops out_valid.
  always_comb begin
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (clear) begin
      sum_d       = '0;
      cnt_d       = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      sum_d       = sum_next;
      cnt_d       = (cnt_q == DEPTH_CNT) ? cnt_q : cnt_q + 1'b1;
      out_data_d  = (MODE == MA_SUM) ? sum_next : (sum_next >>> LOG2_DEPTH);
      out_valid_d = !((WARMUP != 0) && (cnt_d != DEPTH_CNT));
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      sum_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_sum     = sum_q;
  assign window_full = (cnt_q == DEPTH_CNT);

endmodule

// File: tb/tb_moving_average_stream.sv
// Directed bench: three filter variants share one stimulus stream; each
// phase checks the variant it targets against hand-computed values.
module tb_moving_average_stream;
  import moving_average_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              out_ready = 1'b1;

  logic              avg_in_ready, avg_out_valid, avg_full;
  logic signed [11:0] avg_out_data, avg_out_sum;
  logic              sum_in_ready, sum_out_valid, sum_full;
  logic signed [11:0] sum_out_data, sum_out_sum;
  logic              flr_in_ready, flr_out_valid, flr_full;
  logic signed [11:0] flr_out_data, flr_out_sum;

  int test_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  // Defaults: AVERAGE with warm-up.
  moving_average_stream u_avg (
    .system1000(clk), .system1000_rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(avg_in_ready), .in_data(in_data),
    .out_valid(avg_out_valid), .out_ready(out_ready),
    .out_data(avg_out_data), .out_sum(avg_out_sum), .window_full(avg_full)
  );

  // SUM mode, no warm-up.
  moving_average_stream #(.MODE(MA_SUM), .WARMUP(0)) u_sum (
    .system1000(clk), .system1000_rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(sum_in_ready), .in_data(in_data),
    .out_valid(sum_out_valid), .out_ready(out_ready),
    .out_data(sum_out_data), .out_sum(sum_out_sum), .window_full(sum_full)
  );

  // AVERAGE mode, no warm-up (rounding checks).
  moving_average_stream #(.MODE(MA_AVERAGE), .WARMUP(0)) u_flr (
    .system1000(clk), .system1000_rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(flr_in_ready), .in_data(in_data),
    .out_valid(flr_out_valid), .out_ready(out_ready),
    .out_data(flr_out_data), .out_sum(flr_out_sum), .window_full(flr_full)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One accepted sample; returns #1 after the accepting edge.
  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = 8'(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_avg_valid", avg_out_valid, 0);
    chk("rst_avg_sum",   avg_out_sum,   0);
    chk("rst_avg_full",  avg_full,      0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", avg_in_ready, 1);
    chk("rst_sum_data", sum_out_data, 0);

    // Warm-up: sixteen 10s, then 26
    for (int k = 1; k <= 15; k++) begin
      send(10);
      chk($sformatf("warm_valid_%0d", k), avg_out_valid, 0);
    end
    chk("warm_full_15", avg_full, 0);
    send(10);
    chk("t1_valid16", avg_out_valid, 1);
    chk("t1_sum16",   avg_out_sum,   160);
    chk("t1_data16",  avg_out_data,  10);
    chk("t1_full16",  avg_full,      1);
    send(26);
    chk("t1_sum17",  avg_out_sum,  176);
    chk("t1_data17", avg_out_data, 11);

    // Backpressure: three stalled cycles with a sample waiting
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd50;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_ready_%0d", k), avg_in_ready,  0);
      chk($sformatf("bp_sum_%0d", k),   avg_out_sum,   176);
      chk($sformatf("bp_data_%0d", k),  avg_out_data,  11);
      chk($sformatf("bp_valid_%0d", k), avg_out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", avg_in_ready, 1);
    send(50);
    chk("bp_sum_a",  avg_out_sum,  216);
    chk("bp_data_a", avg_out_data, 13);
    send(60);
    chk("bp_sum_b",  avg_out_sum,  266);
    chk("bp_data_b", avg_out_data, 16);
    @(posedge clk);
    #1;
    chk("idle_drop_valid", avg_out_valid, 0);

    // SUM mode, no warm-up: 5, -3, 7
    pulse_clear();
    chk("clr_sum_valid", sum_out_valid, 0);
    chk("clr_sum_sum",   sum_out_sum,   0);
    chk("clr_avg_full",  avg_full,      0);
    send(5);
    chk("t2_valid_a", sum_out_valid, 1);
    chk("t2_data_a",  sum_out_data,  5);
    send(-3);
    chk("t2_data_b",  sum_out_data,  2);
    send(7);
    chk("t2_data_c",  sum_out_data,  9);

    // Clear with a sample offered in the same cycle
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd100;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("t6_valid", sum_out_valid, 0);
    chk("t6_sum",   sum_out_sum,   0);
    chk("t6_data",  sum_out_data,  0);
    chk("t6_full",  sum_full,      0);
    send(4);
    chk("t6_after_sum", sum_out_sum,   4);
    chk("t6_avg_warm",  avg_out_valid, 0);

    // Extremes: sixteen -128 then sixteen 127
    pulse_clear();
    for (int k = 1; k <= 16; k++) begin
      send(-128);
      chk($sformatf("t3_neg_%0d", k), sum_out_sum, -128 * k);
    end
    chk("t3_neg_avg_sum",  avg_out_sum,  -2048);
    chk("t3_neg_avg_data", avg_out_data, -128);
    for (int k = 1; k <= 16; k++) begin
      send(127);
      chk($sformatf("t3_pos_%0d", k), sum_out_sum, -2048 + 255 * k);
    end
    chk("t3_pos_avg_sum",  avg_out_sum,  2032);
    chk("t3_pos_avg_data", avg_out_data, 127);
    chk("t3_pos_valid",    avg_out_valid, 1);

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", avg_out_valid, 0);
    chk("arst_sum",   avg_out_sum,   0);
    chk("arst_data",  avg_out_data,  0);
    chk("arst_full",  avg_full,      0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ready", avg_in_ready, 1);

    // Floor toward -inf: -1 then zeros
    send(-1);
    chk("t4_sum0",  flr_out_sum,  -1);
    chk("t4_data0", flr_out_data, -1);
    for (int k = 1; k <= 15; k++) begin
      send(0);
      chk($sformatf("t4_data_%0d", k), flr_out_data, -1);
    end
    send(0);
    chk("t4_data_out", flr_out_data, 0);
    chk("t4_sum_out",  flr_out_sum,  0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
